fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- In-order instruction fetch stage. Sits directly upstream of the instruction queue.
- Generates sequential PCs and issues word requests to the instruction memory over a request/grant, in-order response interface.
- Pushes fetched instructions (bits [31:2]) into the queue. Handles back-pressure from queue-full with an internal skid buffer.
- On branch redirect, flushes the queue and discards stale in-flight responses.

Parameters:
XLEN, 32, width of PC and memory address
RESET_PC, 32'h0000_0000, PC loaded on reset (zero-extended to XLEN)
MAX_OUTSTANDING, 2, maximum requests in flight plus skid entries (power of 2, >=1)

Ports:
clock  in  1  clock
resetn  in  1  asynchronous active-low reset
redirect  in  1  branch/exception redirect strobe
redirectPc  in  XLEN  new fetch target
imemReq  out  1  memory request valid
imemAddr  out  XLEN  request address (word aligned)
imemGnt  in  1  request accepted this cycle
imemRvalid  in  1  response valid (in order)
imemRdata  in  32  response instruction
queueFull  in  1  queue cannot accept a push
queueFlush  out  1  flush strobe to queue
push  out  1  push strobe to queue
instrOut  out  30  instruction [31:2] to queue
fetchFault  out  1  pulses when a pushed word has rdata[1:0] != 2'b11

Behaviour:
- Reset (async, resetn low): pc=RESET_PC with [1:0] forced 0; outstanding=0; dropCount=0; skid empty. All outputs 0. Reset mid-transaction abandons all in-flight state; the memory shares the same reset.
- Credit: credit = MAX_OUTSTANDING - outstanding - skidCount.
- imemReq = !redirect && credit>0. Combinational from registers plus redirect.
- imemAddr = pc.
- On imemReq && imemGnt: pc <= pc+4 (wraps modulo 2^XLEN) and outstanding increments.
- Response on imemRvalid; each response decrements outstanding. A grant and a response in the same cycle leave outstanding unchanged.
  - If dropCount>0: discard the response and decrement dropCount.
  - Else if skid is empty and !queueFull: push=1 and instrOut=imemRdata[31:2] the same cycle (zero latency from response).
  - Else: write the response into the skid tail.
- Skid drain: if skid is non-empty and !queueFull, push the skid head. A response arriving the same cycle goes to the skid tail, preserving order. At most one push per cycle.
- Skid never overflows; this is guaranteed by credit.
- fetchFault is asserted with push when the pushed word's low bits != 2'b11. The word is still pushed; decode traps.
- Redirect (highest priority, single cycle):
  - pc <= {redirectPc[XLEN-1:2],2'b00}
  - skid cleared
  - dropCount <= outstanding - (imemRvalid && dropCount==0 ? 1 : 0) + dropCount adjustments. Effectively every in-flight response not yet received is dropped.
  - queueFlush=1; push=0; imemReq=0.
  - First request at the new target is issued the next cycle.
- Back-to-back redirects: the latest target wins; dropCount remains correct.
- Memory is never required to cancel a granted request.

Decomposition:
- Package thor_fetch_pkg: INSTR_W=30, NOP_INSTR=32'h00000013, function instr_compress(word) returning [31:2].
- Sub-module fetch_skid_buffer: MAX_OUTSTANDING-deep, 30+1-bit circular buffer with push, pop, clear, count, head. Async reset.

Test Plan:
- Reset, gnt=1 always, rvalid one cycle after grant, queue never full -> imemAddr 0,4,8,...; push each cycle from cycle 2; instrOut = rdata[31:2].
- Hold queueFull=1 for 5 cycles with MAX_OUTSTANDING=2 -> two responses land in skid; imemReq drops to 0. After release, pushes drain in order, one per cycle.
- Redirect to 32'h0000_1002 with 2 outstanding -> queueFlush pulse; next imemAddr=32'h0000_1000; the two stale responses are not pushed; first push is the word from 0x1000.
- Redirect in the same cycle as imemRvalid -> that response is not pushed; dropCount covers the remaining one; no extra response is dropped.
- Response rdata=32'h0000_0001 -> push with fetchFault=1; instrOut=30'h0.
- Assert resetn low while 2 outstanding and skid full -> all outputs 0 immediately; after release, imemAddr=RESET_PC.

Source files
------------

// File: rtl/thor_fetch_pkg.sv
// Shared types and helpers for the fetch stage: the 30-bit instruction payload
// and the skid entry format, which carries a fault flag beside the payload.
package thor_fetch_pkg;

    localparam int INSTR_W = 30;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0] WORD_OK_BITS = 2'b11;

    typedef struct packed {
        logic               fault;
        logic [INSTR_W-1:0] instr;
    } skid_entry_t;

    function automatic logic [INSTR_W-1:0] instr_compress(input logic [31:0] word);
        return word[31:2];
    endfunction

    // The fault is judged on arrival so the skid only has to hold one extra bit.
    function automatic skid_entry_t make_entry(input logic [31:0] word);
        skid_entry_t e;
        e.instr = instr_compress(word);
        e.fault = (word[1:0] != WORD_OK_BITS);
        return e;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Small circular FIFO that holds responses which could not be pushed into the
// queue on arrival. The caller guarantees it never pushes when full or pops when empty.
module fetch_skid_buffer
    import thor_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = $bits(skid_entry_t)
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_head_next;
    logic [PTR_W-1:0] w_tail_next;

    assign w_head_next = (r_head == PTR_LAST) ? '0 : r_head + PTR_W'(1);
    assign w_tail_next = (r_tail == PTR_LAST) ? '0 : r_tail + PTR_W'(1);

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= w_tail_next;
            if (i_pop)  r_head <= w_head_next;
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // Payload storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clock) begin
        if (i_push && !i_clear) r_mem[r_tail] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// In-order fetch stage: issues sequential word requests under a credit limit,
// pushes responses to the instruction queue, and drops stale responses after a redirect.
module fetch_unit
    import thor_fetch_pkg::*;
#(
    parameter int          XLEN            = 32,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirectPc,
    output logic               imemReq,
    output logic [XLEN-1:0]    imemAddr,
    input  logic               imemGnt,
    input  logic               imemRvalid,
    input  logic [31:0]        imemRdata,
    input  logic               queueFull,
    output logic               queueFlush,
    output logic               push,
    output logic [INSTR_W-1:0] instrOut,
    output logic               fetchFault
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CREDIT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [XLEN-1:0]  PC_RESET_RAW = XLEN'(RESET_PC);
    localparam logic [XLEN-1:0]  PC_RESET     = {PC_RESET_RAW[XLEN-1:2], 2'b00};

    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_count;

    logic [CNT_W-1:0] w_skid_count;
    logic             w_skid_empty;
    skid_entry_t      w_skid_head;
    skid_entry_t      w_rsp_entry;
    skid_entry_t      w_push_entry;
    logic [CNT_W-1:0] w_credit;
    logic             w_grant;
    logic             w_rsp_live;
    logic             w_rsp_drop;
    logic             w_skid_pop;
    logic             w_direct;
    logic             w_skid_push;
    logic [1:0]       w_unused_pc_bits;

    assign w_unused_pc_bits = redirectPc[1:0];

    // Skid entries hold credit too, so a stalled queue throttles new requests.
    assign w_credit = MAX_CREDIT - r_outstanding - w_skid_count;

    assign imemReq  = resetn && !redirect && (w_credit != '0);
    assign imemAddr = r_pc;
    assign w_grant  = imemReq && imemGnt;

    assign w_rsp_drop  = imemRvalid && (r_drop_count != '0);
    assign w_rsp_live  = imemRvalid && (r_drop_count == '0);
    assign w_rsp_entry = make_entry(imemRdata);

    // The skid head always goes first; a live response behind it queues at the tail.
    assign w_skid_pop  = !redirect && !w_skid_empty && !queueFull;
    assign w_direct    = !redirect && w_rsp_live && w_skid_empty && !queueFull;
    assign w_skid_push = !redirect && w_rsp_live && !w_direct;

    assign w_push_entry = w_skid_pop ? w_skid_head : w_rsp_entry;

    assign push       = resetn && (w_skid_pop || w_direct);
    assign instrOut   = push ? w_push_entry.instr : '0;
    assign fetchFault = push && w_push_entry.fault;
    assign queueFlush = resetn && redirect;

    fetch_skid_buffer #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH ($bits(skid_entry_t))
    ) u_skid (
        .clock   (clock),
        .resetn  (resetn),
        .i_push  (w_skid_push),
        .i_pop   (w_skid_pop),
        .i_clear (redirect),
        .i_data  (w_rsp_entry),
        .o_head  (w_skid_head),
        .o_count (w_skid_count),
        .o_empty (w_skid_empty)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc          <= PC_RESET;
            r_outstanding <= '0;
            r_drop_count  <= '0;
        end else if (redirect) begin
            // No grant is possible here; whatever is still in flight after this
            // cycle's response (if any) belongs to the old path.
            r_pc          <= {redirectPc[XLEN-1:2], 2'b00};
            r_outstanding <= r_outstanding - CNT_W'(imemRvalid);
            r_drop_count  <= r_outstanding - CNT_W'(imemRvalid);
        end else begin
            if (w_grant) r_pc <= r_pc + XLEN'(4);
            r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(imemRvalid);
            if (w_rsp_drop) r_drop_count <= r_drop_count - CNT_W'(1);
        end
    end

endmodule
